// File: rtl/dice_pattern_reader_if.sv
// dice_pattern_reader_if: pip inputs and decoded face outputs of the dice reader.
interface dice_pattern_reader_if;
    logic [6:0] i_Pips;
    logic [2:0] o_Number;
    logic       o_Valid;
    logic       o_Error;
    logic [7:0] o_Roll_Count;
    modport master (output i_Pips, input o_Number, o_Valid, o_Error, o_Roll_Count);
    modport slave (input i_Pips, output o_Number, o_Valid, o_Error, o_Roll_Count);
endinterface

// File: rtl/dice_pattern_reader.sv
// dice_pattern_reader: debounces a 7-pip die face and reports accepted rolls.
module dice_pattern_reader #(
    parameter int STABLE_CYCLES = 250000
) (
    input logic i_Clk,
    input logic i_Reset,
    dice_pattern_reader_if.slave bus
);
    localparam int W = $clog2(STABLE_CYCLES);
    localparam logic [W-1:0] LAST = W'(STABLE_CYCLES - 1);
    typedef enum logic [1:0] {SETTLING, LOCKED, FAULT} state_t;
    state_t state;
    logic [6:0] sync1, sync2, cand;
    logic [W-1:0] cnt, cnt_next;
    logic [2:0] face;
    logic legal;
    assign cnt_next = cnt + W'(1);
    always_comb begin
        face = 3'd0;
        legal = 1'b1;
        case (cand)
            7'b0000000: face = 3'd0;
            7'b0001000: face = 3'd1;
            7'b1000001: face = 3'd2;
            7'b1001001: face = 3'd3;
            7'b1010101: face = 3'd4;
            7'b1011101: face = 3'd5;
            7'b1110111: face = 3'd6;
            default: legal = 1'b0;
        endcase
    end
    // Acceptance happens on the edge where the count reaches its final value.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cand <= '0;
            cnt <= '0;
            state <= SETTLING;
            bus.o_Number <= '0;
            bus.o_Valid <= 1'b0;
            bus.o_Error <= 1'b0;
            bus.o_Roll_Count <= '0;
        end else begin
            sync1 <= bus.i_Pips;
            sync2 <= sync1;
            bus.o_Valid <= 1'b0;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt <= '0;
                state <= SETTLING;
            end else if (state == SETTLING) begin
                cnt <= cnt_next;
                if (cnt_next == LAST) begin
                    if (legal) begin
                        state <= LOCKED;
                        bus.o_Number <= face;
                        bus.o_Error <= 1'b0;
                        if (face != 3'd0) begin
                            bus.o_Valid <= 1'b1;
                            bus.o_Roll_Count <= bus.o_Roll_Count + 8'd1;
                        end
                    end else begin
                        state <= FAULT;
                        bus.o_Error <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/dice_pattern_reader.md
DICE_PATTERN_READER -- requirements
Module: dice_pattern_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 250000, SHALL set the cycles a synchronized pattern must hold unchanged before it is accepted (legal range 2..2^20).
REQ-002 i_Clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-003 i_Reset  input  1  synchronous active-high reset, sampled on the rising edge of i_Clk.
REQ-004 i_Pips  input  7  asynchronous pip lines: [6]TL [5]ML [4]BL [3]C [2]TR [1]MR [0]BR, 1 = pip lit.
REQ-005 o_Number  output  3  last accepted face value, 0 (blank) or 1..6.
REQ-006 o_Valid  output  1  one-cycle strobe when a new non-blank face is accepted.
REQ-007 o_Error  output  1  level; high while an illegal pattern is held stable.
REQ-008 o_Roll_Count  output  8  count of o_Valid strobes since reset.

Function
REQ-009 i_Pips SHALL pass through a two-flop synchronizer; only the second stage (S) feeds downstream logic.
REQ-010 Legal patterns SHALL decode as: 0000000->0, 0001000->1, 1000001->2, 1001001->3, 1010101->4, 1011101->5, 1110111->6; every other value is illegal.
REQ-011 The block SHALL hold a candidate register CAND and a stability counter CNT of ceil(log2(STABLE_CYCLES)) bits.
REQ-012 States SHALL be SETTLING, LOCKED and FAULT.
REQ-013 In any state, S != CAND SHALL load CAND <= S, clear CNT and enter SETTLING in the same edge; o_Number and o_Error are not changed by this edge.
REQ-014 In SETTLING with S == CAND, CNT SHALL increment; when CNT == STABLE_CYCLES-1 the pattern is accepted on that edge.
REQ-015 On acceptance of a legal pattern: state -> LOCKED, o_Number <= decoded value, o_Error <= 0.
REQ-016 On acceptance of a legal non-blank pattern, o_Valid SHALL be 1 for exactly the following cycle and o_Roll_Count SHALL increment by 1, wrapping 255 -> 0.
REQ-017 Acceptance of the blank pattern SHALL produce no o_Valid and no count change.
REQ-018 On acceptance of an illegal pattern: state -> FAULT, o_Error <= 1, o_Number holds its previous value, no o_Valid.
REQ-019 LOCKED and FAULT SHALL hold all outputs while S == CAND; CNT does not advance.
REQ-020 Re-acceptance of the same face after a glitch shorter than STABLE_CYCLES SHALL still strobe o_Valid and count; each acceptance is a roll.
REQ-021 Latency: a pattern first presented before edge k and held SHALL produce o_Valid high in the cycle after edge k+1+STABLE_CYCLES.
REQ-022 o_Valid SHALL be a registered output, low in every cycle other than those defined in REQ-016.

Reset
REQ-023 i_Reset high SHALL set synchronizer flops = 0, CAND = 0, CNT = 0, state = SETTLING, o_Number = 0, o_Valid = 0, o_Error = 0, o_Roll_Count = 0, overriding all other updates on that edge.
REQ-024 Reset asserted mid-SETTLING or mid-strobe SHALL cancel the pending acceptance and any o_Valid; the first cycle after deassertion SHALL show all outputs at reset values.
REQ-025 After reset with i_Pips = 0, the block SHALL reach LOCKED with o_Number = 0 after STABLE_CYCLES cycles and produce no o_Valid.

Verification (STABLE_CYCLES = 4)
REQ-026 Reset, then hold 1011101 -> single o_Valid pulse at the cycle defined in REQ-021, o_Number = 5, o_Roll_Count = 1, o_Error = 0.
REQ-027 Hold 1110111, toggle bit 0 for 2 cycles, restore -> no change until re-accepted; then o_Valid once, o_Number = 6, o_Roll_Count increments.
REQ-028 From o_Number = 3, hold 1111111 -> o_Error = 1, o_Number stays 3, no o_Valid; then hold 0001000 -> o_Error = 0, o_Number = 1, o_Valid once.
REQ-029 Drive 256 accepted non-blank faces alternating 2 and 4 with blank gaps -> o_Roll_Count wraps to 0; blanks produce no strobes.
REQ-030 Assert i_Reset one cycle before an expected o_Valid -> no strobe, all outputs 0 after release, count stays 0.
